// File: rtl/divmod_ctrl_pkg.sv
// Shared types and constants for the divide sequencer and its bypass detector.
package divmod_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LAUNCH = 2'd1,
      WAIT   = 2'd2,
      RESP   = 2'd3
   } div_ctrl_state_e;

   typedef struct packed {
      logic        is64;
      logic        sgn;
      logic [63:0] num;
      logic [63:0] denom;
   } div_req_t;

   typedef struct packed {
      logic [63:0] quot;
      logic [63:0] rem;
      logic        dbz;
      logic        timeout;
   } div_rsp_t;

   localparam logic [31:0] MIN32  = 32'h8000_0000;
   localparam logic [63:0] MIN64  = 64'h8000_0000_0000_0000;
   localparam logic [31:0] ONES32 = 32'hFFFF_FFFF;
   localparam logic [63:0] ONES64 = 64'hFFFF_FFFF_FFFF_FFFF;

   function automatic logic [63:0] zext32(input logic [31:0] v);
      return {32'h0, v};
   endfunction

endpackage

// File: rtl/divmod_ctrl_bypass_detect.sv
// Combinational detection of divide-by-zero and signed MIN/-1 overflow, with the
// architectural results for those cases so no divider needs to be launched.
module divmod_ctrl_bypass_detect
   import divmod_ctrl_pkg::*;
(
   input  logic        is64,
   input  logic        sgn,
   input  logic [63:0] num,
   input  logic [63:0] denom,
   output logic        is_dbz,
   output logic        is_ovf,
   output logic [63:0] quot,
   output logic [63:0] rem
);

   logic signed [31:0] denom32_s;
   logic signed [63:0] denom64_s;

   always_comb begin
      denom32_s = denom[31:0];
      denom64_s = denom;
      is_dbz    = is64 ? (denom == '0) : (denom[31:0] == '0);
      if (is64) begin
         is_ovf = sgn && (num == MIN64) && (denom64_s == -64'sd1);
      end else begin
         is_ovf = sgn && (num[31:0] == MIN32) && (denom32_s == -32'sd1);
      end

      quot = '0;
      rem  = '0;
      if (is_dbz) begin
         quot = is64 ? ONES64 : zext32(ONES32);
         rem  = is64 ? num : zext32(num[31:0]);
      end else if (is_ovf) begin
         // MIN / -1 wraps back to MIN with no remainder
         quot = is64 ? num : zext32(num[31:0]);
      end
   end

endmodule

// File: rtl/divmod_ctrl.sv
// Sequencer between the execute stage and the 32/64-bit non-restoring dividers:
// one command in flight, bypass for dbz/overflow, launch watchdog and flush.
module divmod_ctrl
   import divmod_ctrl_pkg::*;
#(
   parameter int TAG_W          = 4,
   parameter int TIMEOUT_CYCLES = 255
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_is64,
   input  logic              req_signed,
   input  logic [63:0]       req_num,
   input  logic [63:0]       req_denom,
   input  logic [TAG_W-1:0]  req_tag,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [63:0]       rsp_quot,
   output logic [63:0]       rsp_rem,
   output logic [TAG_W-1:0]  rsp_tag,
   output logic              rsp_dbz,
   output logic              rsp_timeout,
   output logic              div32_enable,
   output logic              div32_unsgn_or_sgn,
   output logic [31:0]       div32_num,
   output logic [31:0]       div32_denom,
   input  logic [31:0]       div32_quot,
   input  logic [31:0]       div32_rem,
   input  logic              div32_can_accept_cmd,
   input  logic              div32_data_ready,
   output logic              div64_enable,
   output logic              div64_unsgn_or_sgn,
   output logic [63:0]       div64_num,
   output logic [63:0]       div64_denom,
   input  logic [63:0]       div64_quot,
   input  logic [63:0]       div64_rem,
   input  logic              div64_can_accept_cmd,
   input  logic              div64_data_ready
);

   localparam int              WD_W    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

   div_ctrl_state_e state, state_next;
   div_req_t        req_r;
   logic [WD_W-1:0] wd_cnt;

   logic        bp_dbz, bp_ovf;
   logic [63:0] bp_quot, bp_rem;
   logic        accept, launch, timeout_hit;
   logic        sel_can_accept, sel_data_ready;
   logic [63:0] res_quot, res_rem;

   divmod_ctrl_bypass_detect u_bypass (
      .is64   (req_is64),
      .sgn    (req_signed),
      .num    (req_num),
      .denom  (req_denom),
      .is_dbz (bp_dbz),
      .is_ovf (bp_ovf),
      .quot   (bp_quot),
      .rem    (bp_rem)
   );

   always_comb begin
      sel_can_accept = req_r.is64 ? div64_can_accept_cmd : div32_can_accept_cmd;
      sel_data_ready = req_r.is64 ? div64_data_ready : div32_data_ready;
      res_quot       = req_r.is64 ? div64_quot : zext32(div32_quot);
      res_rem        = req_r.is64 ? div64_rem : zext32(div32_rem);
      req_ready      = (state == IDLE) && !flush;
      accept         = req_valid && req_ready;
      launch         = (state == LAUNCH) && sel_can_accept && !flush;
      timeout_hit    = (wd_cnt == WD_LAST);
      rsp_valid      = (state == RESP) && !flush;
      div32_enable   = launch && !req_r.is64;
      div64_enable   = launch && req_r.is64;
   end

   // Operands are held from acceptance; dividers only look at them in the enable cycle
   assign div32_unsgn_or_sgn = req_r.sgn;
   assign div32_num          = req_r.num[31:0];
   assign div32_denom        = req_r.denom[31:0];
   assign div64_unsgn_or_sgn = req_r.sgn;
   assign div64_num          = req_r.num;
   assign div64_denom        = req_r.denom;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      if (flush) begin
         state_next = IDLE;
      end else begin
         unique case (state)
            IDLE:    if (accept) state_next = (bp_dbz || bp_ovf) ? RESP : LAUNCH;
            LAUNCH:  if (sel_can_accept) state_next = WAIT;
            WAIT:    if (sel_data_ready || timeout_hit) state_next = RESP;
            RESP:    if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         req_r       <= '0;
         wd_cnt      <= '0;
         rsp_quot    <= '0;
         rsp_rem     <= '0;
         rsp_tag     <= '0;
         rsp_dbz     <= 1'b0;
         rsp_timeout <= 1'b0;
      end else if (!flush) begin
         unique case (state)
            IDLE: begin
               if (accept) begin
                  req_r.is64  <= req_is64;
                  req_r.sgn   <= req_signed;
                  req_r.num   <= req_num;
                  req_r.denom <= req_denom;
                  rsp_tag     <= req_tag;
                  rsp_dbz     <= bp_dbz;
                  rsp_timeout <= 1'b0;
                  rsp_quot    <= bp_quot;
                  rsp_rem     <= bp_rem;
               end
            end
            LAUNCH: begin
               if (launch) wd_cnt <= '0;
            end
            WAIT: begin
               // A late result in the same cycle as the deadline still wins
               if (sel_data_ready) begin
                  rsp_quot <= res_quot;
                  rsp_rem  <= res_rem;
               end else if (timeout_hit) begin
                  rsp_timeout <= 1'b1;
                  rsp_quot    <= '0;
                  rsp_rem     <= '0;
               end else begin
                  wd_cnt <= wd_cnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_divmod_ctrl.sv
// Scoreboard bench for divmod_ctrl with behavioural divider models and a
// magnitude/sign reference model of the architectural divide results.
module tb_divmod_ctrl;

   localparam int TAG_W = 4;
   localparam int TMO   = 80;

   logic              clk = 1'b0;
   logic              rst;
   logic              flush;
   logic              req_valid, req_ready, req_is64, req_signed;
   logic [63:0]       req_num, req_denom;
   logic [TAG_W-1:0]  req_tag;
   logic              rsp_valid, rsp_ready;
   logic [63:0]       rsp_quot, rsp_rem;
   logic [TAG_W-1:0]  rsp_tag;
   logic              rsp_dbz, rsp_timeout;
   logic              div32_enable, div32_unsgn_or_sgn;
   logic [31:0]       div32_num, div32_denom, div32_quot, div32_rem;
   logic              div32_can_accept_cmd, div32_data_ready;
   logic              div64_enable, div64_unsgn_or_sgn;
   logic [63:0]       div64_num, div64_denom, div64_quot, div64_rem;
   logic              div64_can_accept_cmd, div64_data_ready;

   always #5 clk = ~clk;

   divmod_ctrl #(.TAG_W(TAG_W), .TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .req_valid(req_valid), .req_ready(req_ready), .req_is64(req_is64),
      .req_signed(req_signed), .req_num(req_num), .req_denom(req_denom), .req_tag(req_tag),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_quot(rsp_quot), .rsp_rem(rsp_rem),
      .rsp_tag(rsp_tag), .rsp_dbz(rsp_dbz), .rsp_timeout(rsp_timeout),
      .div32_enable(div32_enable), .div32_unsgn_or_sgn(div32_unsgn_or_sgn),
      .div32_num(div32_num), .div32_denom(div32_denom), .div32_quot(div32_quot),
      .div32_rem(div32_rem), .div32_can_accept_cmd(div32_can_accept_cmd),
      .div32_data_ready(div32_data_ready),
      .div64_enable(div64_enable), .div64_unsgn_or_sgn(div64_unsgn_or_sgn),
      .div64_num(div64_num), .div64_denom(div64_denom), .div64_quot(div64_quot),
      .div64_rem(div64_rem), .div64_can_accept_cmd(div64_can_accept_cmd),
      .div64_data_ready(div64_data_ready)
   );

   typedef struct {
      logic [63:0]      quot;
      logic [63:0]      rem;
      logic [TAG_W-1:0] tag;
      logic             dbz;
      logic             tmo;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   en32_cnt = 0, en64_cnt = 0, en32_cyc = 0, rsp_rise_cyc = 0;
   bit   blk32 = 0, blk64 = 0, hold32 = 0, hold64 = 0, hold_rdy = 0;
   bit   busy32 = 0, busy64 = 0;

   always @(posedge clk) cyc <= cyc + 1;

   assign div32_can_accept_cmd = !busy32 && !blk32;
   assign div64_can_accept_cmd = !busy64 && !blk64;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   // Architectural result: truncating division on magnitudes, quotient sign is
   // the xor of operand signs, remainder takes the dividend's sign.
   function automatic exp_t ref_model(input bit is64, input bit sgn, input logic [63:0] num,
                                      input logic [63:0] denom, input logic [TAG_W-1:0] tag,
                                      input bit tmo);
      exp_t        e;
      logic [63:0] mask, n, d, an, ad, mq, mr;
      bit          nneg, dneg;
      mask  = is64 ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
      n     = num & mask;
      d     = denom & mask;
      e.tag = tag;
      e.dbz = 1'b0;
      e.tmo = 1'b0;
      if (d == 64'd0) begin
         e.dbz  = 1'b1;
         e.quot = mask;
         e.rem  = n;
      end else if (tmo) begin
         e.tmo  = 1'b1;
         e.quot = 64'd0;
         e.rem  = 64'd0;
      end else begin
         if (sgn && !is64) begin
            n = {{32{n[31]}}, n[31:0]};
            d = {{32{d[31]}}, d[31:0]};
         end
         nneg   = sgn && n[63];
         dneg   = sgn && d[63];
         an     = nneg ? -n : n;
         ad     = dneg ? -d : d;
         mq     = an / ad;
         mr     = an % ad;
         e.quot = ((nneg ^ dneg) ? -mq : mq) & mask;
         e.rem  = (nneg ? -mr : mr) & mask;
      end
      return e;
   endfunction

   initial begin : div32_model
      logic        en, s;
      logic [31:0] n, d, q, r;
      int          cnt;
      div32_data_ready = 1'b0;
      div32_quot = '0;
      div32_rem  = '0;
      cnt = 0;
      forever begin
         @(negedge clk);
         en = div32_enable; s = div32_unsgn_or_sgn; n = div32_num; d = div32_denom;
         @(posedge clk);
         #1;
         if (div32_data_ready) begin
            div32_data_ready = 1'b0;
            busy32 = 1'b0;
         end else if (en) begin
            busy32 = 1'b1;
            cnt = $urandom_range(1, 6);
            if (d == '0) begin q = '1; r = n; end
            else if (s && d == '1) begin q = -n; r = '0; end
            else if (s) begin q = $signed(n) / $signed(d); r = $signed(n) % $signed(d); end
            else begin q = n / d; r = n % d; end
         end else if (busy32 && !hold32) begin
            cnt--;
            if (cnt <= 0) begin
               div32_data_ready = 1'b1;
               div32_quot = q;
               div32_rem  = r;
            end
         end
      end
   end

   initial begin : div64_model
      logic        en, s;
      logic [63:0] n, d, q, r;
      int          cnt;
      div64_data_ready = 1'b0;
      div64_quot = '0;
      div64_rem  = '0;
      cnt = 0;
      forever begin
         @(negedge clk);
         en = div64_enable; s = div64_unsgn_or_sgn; n = div64_num; d = div64_denom;
         @(posedge clk);
         #1;
         if (div64_data_ready) begin
            div64_data_ready = 1'b0;
            busy64 = 1'b0;
         end else if (en) begin
            busy64 = 1'b1;
            cnt = $urandom_range(1, 9);
            if (d == '0) begin q = '1; r = n; end
            else if (s && d == '1) begin q = -n; r = '0; end
            else if (s) begin q = $signed(n) / $signed(d); r = $signed(n) % $signed(d); end
            else begin q = n / d; r = n % d; end
         end else if (busy64 && !hold64) begin
            cnt--;
            if (cnt <= 0) begin
               div64_data_ready = 1'b1;
               div64_quot = q;
               div64_rem  = r;
            end
         end
      end
   end

   initial begin : rsp_ready_driver
      rsp_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         rsp_ready = hold_rdy ? 1'b0 : ($urandom_range(0, 3) != 0);
      end
   end

   initial begin : monitor
      exp_t        e;
      bit          pv, prev_valid, prev_en32, prev_en64;
      logic [63:0] pq, pr;
      logic [TAG_W-1:0] pt;
      logic        pd, pto;
      pv = 0; prev_valid = 0; prev_en32 = 0; prev_en64 = 0;
      pq = '0; pr = '0; pt = '0; pd = 0; pto = 0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (div32_enable) begin
               en32_cnt++;
               en32_cyc = cyc;
               chk("en32_single_cycle", prev_en32, 0);
            end
            if (div64_enable) begin
               en64_cnt++;
               chk("en64_single_cycle", prev_en64, 0);
            end
            if (rsp_valid && !prev_valid) rsp_rise_cyc = cyc;
            if (rsp_valid && pv) begin
               chk("rsp_stable", {rsp_quot ^ pq} | {rsp_rem ^ pr}
                   | 64'({rsp_tag ^ pt, rsp_dbz ^ pd, rsp_timeout ^ pto}), 64'd0);
            end
            if (rsp_valid && rsp_ready) begin
               if (exp_q.size() == 0) begin
                  chk("rsp_unexpected", 64'd1, 64'd0);
               end else begin
                  e = exp_q.pop_front();
                  chk("rsp_quot", rsp_quot, e.quot);
                  chk("rsp_rem", rsp_rem, e.rem);
                  chk("rsp_tag", 64'(rsp_tag), 64'(e.tag));
                  chk("rsp_flags", {62'd0, rsp_dbz, rsp_timeout}, {62'd0, e.dbz, e.tmo});
               end
               pv = 0;
            end else begin
               pv = rsp_valid;
            end
            pq = rsp_quot; pr = rsp_rem; pt = rsp_tag; pd = rsp_dbz; pto = rsp_timeout;
         end
         prev_valid = rsp_valid && !rst;
         prev_en32  = div32_enable;
         prev_en64  = div64_enable;
      end
   end

   task automatic issue(input bit is64, input bit sgn, input logic [63:0] num,
                        input logic [63:0] denom, input logic [TAG_W-1:0] tag, input bit tmo);
      bit ok, rdy;
      ok = 0;
      req_valid = 1'b1; req_is64 = is64; req_signed = sgn;
      req_num = num; req_denom = denom; req_tag = tag;
      for (int n = 0; n < 300 && !ok; n++) begin
         @(negedge clk);
         rdy = req_ready;
         @(posedge clk);
         #1;
         if (rdy) begin
            ok = 1;
            exp_q.push_back(ref_model(is64, sgn, num, denom, tag, tmo));
         end
      end
      req_valid = 1'b0;
      if (!ok) chk("req_accept_timeout", 64'd1, 64'd0);
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 3000) begin
         @(posedge clk);
         n++;
      end
      #1;
      chk(name, 64'(exp_q.size()), 64'd0);
      if (exp_q.size() != 0) begin
         flush = 1'b1;
         @(posedge clk);
         #1;
         flush = 1'b0;
         exp_q.delete();
      end
   endtask

   task automatic do_flush();
      flush = 1'b1;
      if (exp_q.size() != 0) void'(exp_q.pop_back());
      @(posedge clk);
      #1;
      flush = 1'b0;
   endtask

   function automatic logic [63:0] rand_op(input bit is_denom);
      case ($urandom_range(0, 11))
         0:       return is_denom ? 64'd0 : 64'h8000_0000_0000_0000;
         1:       return 64'hFFFF_FFFF_FFFF_FFFF;
         2:       return 64'h0000_0000_8000_0000;
         3, 4:    return 64'($urandom_range(1, 1000));
         5, 6:    return -64'($urandom_range(1, 1000));
         default: return {$urandom, $urandom};
      endcase
   endfunction

   initial begin : watchdog
      #900000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "simulation time limit");
   end

   initial begin : stimulus
      int  e32, e64, got, dly;
      bit  is64, sgn;
      rst = 1'b1; flush = 1'b0; req_valid = 1'b0; req_is64 = 1'b0; req_signed = 1'b0;
      req_num = '0; req_denom = '0; req_tag = '0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("reset_req_ready", 64'(req_ready), 64'd1);
      chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("reset_rsp_quot", rsp_quot, 64'd0);
      chk("reset_rsp_rem", rsp_rem, 64'd0);
      chk("reset_rsp_tag_flags", 64'({rsp_tag, rsp_dbz, rsp_timeout}), 64'd0);
      chk("reset_enables", 64'({div32_enable, div64_enable}), 64'd0);
      chk("reset_div_operands", div64_num | div64_denom | 64'({div32_num, div32_denom}), 64'd0);
      @(posedge clk);
      #1;

      e32 = en32_cnt; e64 = en64_cnt;
      issue(0, 0, 64'd100, 64'd7, 4'h5, 0);
      drain("u32_100_7_done");
      chk("u32_en32_pulses", 64'(en32_cnt - e32), 64'd1);
      chk("u32_en64_idle", 64'(en64_cnt - e64), 64'd0);

      e32 = en32_cnt; e64 = en64_cnt;
      issue(1, 1, -64'd100, 64'd7, 4'h9, 0);
      drain("s64_m100_7_done");
      chk("s64_en64_pulses", 64'(en64_cnt - e64), 64'd1);
      chk("s64_en32_idle", 64'(en32_cnt - e32), 64'd0);

      e32 = en32_cnt; e64 = en64_cnt;
      issue(0, 0, 64'h1234, 64'hFFFF_FFFF_0000_0000, 4'h3, 0);
      @(negedge clk);
      chk("dbz_latency_rsp_valid", 64'(rsp_valid), 64'd1);
      drain("dbz32_done");
      chk("dbz_no_enable", 64'(en32_cnt - e32 + en64_cnt - e64), 64'd0);

      e32 = en32_cnt; e64 = en64_cnt;
      issue(0, 1, 64'h8000_0000, 64'hFFFF_FFFF, 4'hC, 0);
      drain("ovf32_done");
      chk("ovf_no_enable", 64'(en32_cnt - e32 + en64_cnt - e64), 64'd0);

      // Launch stalls on a busy divider; flush during the stall must cancel it
      blk32 = 1;
      repeat (2) @(posedge clk);
      #1;
      e32 = en32_cnt;
      issue(0, 0, 64'd1000, 64'd3, 4'h6, 0);
      repeat (2) @(posedge clk);
      #1;
      do_flush();
      @(negedge clk);
      chk("flush_back_to_idle", 64'({req_ready, rsp_valid}), 64'b10);
      @(posedge clk);
      #1;
      blk32 = 0;
      repeat (3) @(posedge clk);
      #1;
      chk("flush_no_enable", 64'(en32_cnt - e32), 64'd0);
      issue(0, 0, 64'd999, 64'd10, 4'h7, 0);
      drain("after_flush_done");
      chk("after_flush_one_enable", 64'(en32_cnt - e32), 64'd1);

      // Withheld result: watchdog fires, response held under back-pressure
      hold32 = 1; hold_rdy = 1;
      repeat (2) @(posedge clk);
      #1;
      e32 = en32_cnt;
      issue(0, 0, 64'd77, 64'd5, 4'hA, 1);
      got = 0;
      for (int i = 0; i < 300 && got == 0; i++) begin
         @(negedge clk);
         got = rsp_valid;
      end
      chk("tmo_rsp_seen", 64'(got), 64'd1);
      chk("tmo_flag", 64'(rsp_timeout), 64'd1);
      repeat (3) @(posedge clk);
      #1;
      chk("tmo_latency", 64'(rsp_rise_cyc - en32_cyc), 64'(TMO + 1));
      hold_rdy = 0;
      drain("tmo_done");
      hold32 = 0;
      issue(0, 1, -64'd50, 64'd6, 4'hB, 0);
      drain("after_tmo_done");
      chk("after_tmo_enables", 64'(en32_cnt - e32), 64'd2);

      for (int k = 0; k < 150; k++) begin
         is64 = $urandom_range(0, 1);
         sgn  = $urandom_range(0, 1);
         issue(is64, sgn, rand_op(0), rand_op(1), TAG_W'($urandom), 0);
         if ($urandom_range(0, 6) == 0) begin
            dly = $urandom_range(0, 10);
            repeat (dly) @(posedge clk);
            #1;
            do_flush();
         end
         drain("rand_done");
      end

      repeat (20) @(posedge clk);
      #1;
      chk("final_queue_empty", 64'(exp_q.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
